// File: rtl/rf_overdrive_protect.sv
// Multi-channel RF overdrive/slew protection: window power sums (TSSI), ODP/SRP trip FSM gating PA enable.
// Latency: tssi/tssi_valid/trips register on the sample edge; pa_disable follows the state register.
// Backpressure: none; sample_valid is a strobe that is always accepted. Optional: RF_PROT_AUTO_RECOVER_EN.
module rf_overdrive_protect #(
    parameter int NUM_CH           = 8,
    parameter int PWR_W            = 17,
    parameter int HOLDOFF_CYC      = 1024,
    parameter int AUTO_RECOVER_CYC = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [NUM_CH*PWR_W-1:0] sample_pwr,
    input  logic [31:0]           rf_overdrive_thresh,
    input  logic [20:0]           rf_overdrive_avg_per,
    input  logic [PWR_W-1:0]      rf_slew_limit,
    input  logic [15:0]           rf_slew_duration_limit,
    input  logic [NUM_CH-1:0]     disable_rf_odp,
    input  logic [NUM_CH-1:0]     disable_rf_srp,
    input  logic [NUM_CH-1:0]     trip_clear,
    output logic [NUM_CH*32-1:0]  rf_overdrive_tssi,
    output logic                  tssi_valid,
    output logic [NUM_CH-1:0]     odp_trip,
    output logic [NUM_CH-1:0]     srp_trip,
    output logic [NUM_CH-1:0]     pa_disable
);

    localparam int ACC_W = PWR_W + 21;
    localparam int EXT_W = (ACC_W > 32) ? ACC_W : 33;
    localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic [1:0] {ST_ARMED, ST_TRIPPED, ST_HOLDOFF} ch_state_t;

    if (HOLDOFF_CYC < 1 || AUTO_RECOVER_CYC < 1) begin : g_bad_param
        $error("HOLDOFF_CYC and AUTO_RECOVER_CYC must be >= 1");
    end

    // Shared window counter; the period is captured on the window's first sample.
    logic [20:0] win_cnt;
    logic [20:0] per_lat;
    logic [20:0] per_cur;
    logic        win_close;
    logic [15:0] dur_eff;

    always_comb begin
        per_cur = per_lat;
        if (win_cnt == 21'd0)
            per_cur = (rf_overdrive_avg_per == 21'd0) ? 21'd1 : rf_overdrive_avg_per;
    end

    assign win_close = sample_valid && ((win_cnt + 21'd1) == per_cur);
    assign dur_eff   = (rf_slew_duration_limit == 16'd0) ? 16'd1 : rf_slew_duration_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt    <= '0;
            per_lat    <= '0;
            tssi_valid <= 1'b0;
        end else begin
            tssi_valid <= win_close;
            if (sample_valid) begin
                if (win_cnt == 21'd0)
                    per_lat <= per_cur;
                win_cnt <= win_close ? 21'd0 : win_cnt + 21'd1;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [PWR_W-1:0] smp;
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] sum;
        logic [EXT_W-1:0] sum_ext;
        logic [31:0]      sum_sat;
        logic [31:0]      tssi_q;
        logic [PWR_W-1:0] prev;
        logic             prev_valid;
        logic [PWR_W-1:0] delta;
        logic             viol;
        logic [15:0]      run_cnt;
        logic [15:0]      run_nxt;
        logic             odp_evt;
        logic             srp_evt;
        logic             odp_q;
        logic             srp_q;
        logic [HO_W-1:0]  ho_cnt;
        ch_state_t        state;
        ch_state_t        state_nxt;
        logic             enter_ho;
        logic             detect_en;
`ifdef RF_PROT_AUTO_RECOVER_EN
        localparam int AR_W = $clog2(AUTO_RECOVER_CYC + 1);
        logic [AR_W-1:0]  ar_cnt;
`endif

        assign smp     = sample_pwr[ch*PWR_W +: PWR_W];
        assign sum     = acc + ACC_W'(smp);
        assign sum_ext = EXT_W'(sum);
        assign sum_sat = (sum_ext > EXT_W'(64'hFFFF_FFFF)) ? 32'hFFFF_FFFF : sum_ext[31:0];
        assign odp_evt = win_close && (sum_sat > rf_overdrive_thresh) && !disable_rf_odp[ch];

        assign delta   = (smp > prev) ? (smp - prev) : '0;
        assign viol    = delta > rf_slew_limit;
        assign run_nxt = !viol ? 16'd0 : ((run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1);
        assign srp_evt = sample_valid && prev_valid && viol && (run_nxt >= dur_eff) &&
                         !disable_rf_srp[ch];

        always_comb begin
            state_nxt = state;
            enter_ho  = 1'b0;
            case (state)
                ST_ARMED: begin
                    if (odp_evt || srp_evt)
                        state_nxt = ST_TRIPPED;
                end
                ST_TRIPPED: begin
                    if (trip_clear[ch]) begin
                        state_nxt = ST_HOLDOFF;
                        enter_ho  = 1'b1;
                    end
`ifdef RF_PROT_AUTO_RECOVER_EN
                    else if (ar_cnt == AR_W'(AUTO_RECOVER_CYC - 1)) begin
                        state_nxt = ST_HOLDOFF;
                        enter_ho  = 1'b1;
                    end
`endif
                end
                ST_HOLDOFF: begin
                    if (ho_cnt == HO_W'(HOLDOFF_CYC - 1))
                        state_nxt = ST_ARMED;
                end
                default: state_nxt = ST_ARMED;
            endcase
        end

        // A clear on the same edge as a new event wins, so detection is masked off.
        assign detect_en = (state != ST_HOLDOFF) && !enter_ho;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state      <= ST_ARMED;
                acc        <= '0;
                tssi_q     <= '0;
                odp_q      <= 1'b0;
                srp_q      <= 1'b0;
                prev       <= '0;
                prev_valid <= 1'b0;
                run_cnt    <= '0;
                ho_cnt     <= '0;
            end else begin
                state <= state_nxt;
                if (win_close)
                    tssi_q <= sum_sat;
                if (sample_valid)
                    acc <= win_close ? '0 : sum;

                if (enter_ho)
                    odp_q <= 1'b0;
                else if (detect_en && odp_evt)
                    odp_q <= 1'b1;
                if (enter_ho)
                    srp_q <= 1'b0;
                else if (detect_en && srp_evt)
                    srp_q <= 1'b1;

                if (sample_valid)
                    prev <= smp;
                if (state == ST_HOLDOFF && state_nxt == ST_ARMED)
                    prev_valid <= 1'b0;
                else if (sample_valid)
                    prev_valid <= 1'b1;

                if (enter_ho || state == ST_HOLDOFF)
                    run_cnt <= '0;
                else if (sample_valid && prev_valid)
                    run_cnt <= run_nxt;

                ho_cnt <= (state == ST_HOLDOFF) ? ho_cnt + HO_W'(1) : '0;
            end
        end

`ifdef RF_PROT_AUTO_RECOVER_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                ar_cnt <= '0;
            else if (state == ST_TRIPPED && state_nxt == ST_TRIPPED)
                ar_cnt <= ar_cnt + AR_W'(1);
            else
                ar_cnt <= '0;
        end
`endif

        assign rf_overdrive_tssi[ch*32 +: 32] = tssi_q;
        assign odp_trip[ch]   = odp_q;
        assign srp_trip[ch]   = srp_q;
        assign pa_disable[ch] = (state != ST_ARMED);
    end

endmodule

// File: tb/tb_rf_overdrive_protect.sv
// Bench for rf_overdrive_protect: window/ODP vector table with a TSSI scoreboard, plus SRP/clear/reset sequences.
module tb_rf_overdrive_protect;

    localparam int NUM_CH = 8;
    localparam int PWR_W  = 17;
    localparam int HO     = 16;
    localparam int AR     = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    sample_valid = 1'b0;
    logic [NUM_CH*PWR_W-1:0] sample_pwr = '0;
    logic [31:0]             rf_overdrive_thresh = '1;
    logic [20:0]             rf_overdrive_avg_per = '0;
    logic [PWR_W-1:0]        rf_slew_limit = '1;
    logic [15:0]             rf_slew_duration_limit = '0;
    logic [NUM_CH-1:0]       disable_rf_odp = '0;
    logic [NUM_CH-1:0]       disable_rf_srp = '0;
    logic [NUM_CH-1:0]       trip_clear = '0;
    logic [NUM_CH*32-1:0]    rf_overdrive_tssi;
    logic                    tssi_valid;
    logic [NUM_CH-1:0]       odp_trip;
    logic [NUM_CH-1:0]       srp_trip;
    logic [NUM_CH-1:0]       pa_disable;

    rf_overdrive_protect #(
        .NUM_CH(NUM_CH), .PWR_W(PWR_W), .HOLDOFF_CYC(HO), .AUTO_RECOVER_CYC(AR)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_pwr(sample_pwr),
        .rf_overdrive_thresh(rf_overdrive_thresh), .rf_overdrive_avg_per(rf_overdrive_avg_per),
        .rf_slew_limit(rf_slew_limit), .rf_slew_duration_limit(rf_slew_duration_limit),
        .disable_rf_odp(disable_rf_odp), .disable_rf_srp(disable_rf_srp), .trip_clear(trip_clear),
        .rf_overdrive_tssi(rf_overdrive_tssi), .tssi_valid(tssi_valid), .odp_trip(odp_trip),
        .srp_trip(srp_trip), .pa_disable(pa_disable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] avg;
        logic [31:0] thresh;
        logic [16:0] smp;
        int          n;
        logic [31:0] exp_tssi;
        logic        exp_odp;
    } vec_t;

    typedef struct {
        logic [31:0] tssi;
        logic        odp;
        logic        pa;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_pwr = '0;
        trip_clear = '0;
        disable_rf_odp = '0;
        disable_rf_srp = '0;
        rf_overdrive_thresh = '1;
        rf_slew_limit = '1;
        rf_slew_duration_limit = 16'd1;
        rf_overdrive_avg_per = 21'd1000;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drive(input int ch, input logic [16:0] v);
        sample_pwr = '0;
        sample_pwr[ch*PWR_W +: PWR_W] = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample_pwr = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard consumer: each tssi_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && !rst && tssi_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_tssi_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tssi0", 64'(rf_overdrive_tssi[31:0]), 64'(e.tssi));
                check("odp0", 64'(odp_trip[0]), 64'(e.odp));
                check("pa0_with_tssi_valid", 64'(pa_disable[0]), 64'(e.pa));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{avg: 21'd4, thresh: 32'd1000, smp: 17'd100, n: 4, exp_tssi: 32'd400, exp_odp: 1'b0};
        vecs[1] = '{avg: 21'd4, thresh: 32'd399,  smp: 17'd100, n: 4, exp_tssi: 32'd400, exp_odp: 1'b1};
        vecs[2] = '{avg: 21'd4, thresh: 32'd400,  smp: 17'd100, n: 4, exp_tssi: 32'd400, exp_odp: 1'b0};
        vecs[3] = '{avg: 21'd0, thresh: 32'd0,    smp: 17'd5,   n: 1, exp_tssi: 32'd5,   exp_odp: 1'b1};
        vecs[4] = '{avg: 21'd3, thresh: 32'hFFFF_FFFF, smp: 17'h1FFFF, n: 3,
                    exp_tssi: 32'd393213, exp_odp: 1'b0};
        vecs[5] = '{avg: 21'd40000, thresh: 32'hFFFF_FFFF, smp: 17'h1FFFF, n: 40000,
                    exp_tssi: 32'hFFFF_FFFF, exp_odp: 1'b0};

        rst = 1'b1;
        #12;
        check("rst_tssi", 64'(|rf_overdrive_tssi), 64'd0);
        check("rst_tssi_valid", 64'(tssi_valid), 64'd0);
        check("rst_flags", 64'({odp_trip, srp_trip}), 64'd0);
        check("rst_pa", 64'(pa_disable), 64'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            rf_overdrive_avg_per = vecs[v].avg;
            rf_overdrive_thresh  = vecs[v].thresh;
            mon_en = 1'b1;
            sb.push_back('{tssi: vecs[v].exp_tssi, odp: vecs[v].exp_odp, pa: vecs[v].exp_odp});
            for (int i = 0; i < vecs[v].n; i++) drive(0, vecs[v].smp);
            drain("vec_drain");
            mon_en = 1'b0;
        end

        // Slew run of three violations trips ch2 on the 4th sample.
        do_reset();
        rf_slew_limit = 17'd10;
        rf_slew_duration_limit = 16'd3;
        drive(2, 17'd0); drive(2, 17'd20); drive(2, 17'd40);
        check("srp_before_3rd_viol", 64'(srp_trip[2]), 64'd0);
        drive(2, 17'd60);
        check("srp_at_3rd_viol", 64'(srp_trip[2]), 64'd1);
        check("pa_srp_trip", 64'(pa_disable[2]), 64'd1);

        do_reset();
        rf_slew_limit = 17'd10;
        rf_slew_duration_limit = 16'd3;
        drive(2, 17'd0); drive(2, 17'd20); drive(2, 17'd25); drive(2, 17'd45);
        check("srp_broken_run", 64'({srp_trip[2], pa_disable[2]}), 64'd0);

        do_reset();
        rf_slew_limit = 17'd10;
        rf_slew_duration_limit = 16'd3;
        disable_rf_srp[2] = 1'b1;
        drive(2, 17'd0); drive(2, 17'd20); drive(2, 17'd40); drive(2, 17'd60);
        check("srp_masked", 64'({srp_trip[2], pa_disable[2]}), 64'd0);

        do_reset();
        rf_slew_limit = 17'd10;
        rf_slew_duration_limit = 16'd0;
        drive(2, 17'd0);
        check("srp_first_sample_no_check", 64'(srp_trip[2]), 64'd0);
        drive(2, 17'd20);
        check("srp_dur0_as_1", 64'(srp_trip[2]), 64'd1);

        // ODP trip on ch1, clear, full holdoff with overdrive ignored, then re-arm.
        do_reset();
        rf_overdrive_avg_per = 21'd1;
        rf_overdrive_thresh = 32'd50;
        drive(1, 17'd100);
        check("odp1_trip", 64'({odp_trip[1], pa_disable[1]}), 64'b11);
        trip_clear[4] = 1'b1;
        trip_clear[1] = 1'b1;
        tick();
        trip_clear = '0;
        check("clear_flags", 64'({odp_trip[1], srp_trip[1]}), 64'd0);
        check("clear_pa_held", 64'(pa_disable[1]), 64'd1);
        check("clear_armed_ignored", 64'(pa_disable[4]), 64'd0);
        for (int i = 0; i < HO - 1; i++) begin
            if (i < 8) drive(1, 17'd100);
            else tick();
        end
        check("holdoff_pa_last", 64'(pa_disable[1]), 64'd1);
        check("holdoff_ignored", 64'(odp_trip[1]), 64'd0);
        tick();
        check("holdoff_rearm", 64'(pa_disable[1]), 64'd0);
        drive(1, 17'd100);
        check("rearm_trip_again", 64'(odp_trip[1]), 64'd1);

        // Clear and an SRP event on the same edge: clear wins.
        do_reset();
        rf_slew_limit = 17'd10;
        rf_slew_duration_limit = 16'd1;
        drive(3, 17'd0); drive(3, 17'd20);
        check("srp3_trip", 64'(srp_trip[3]), 64'd1);
        trip_clear[3] = 1'b1;
        drive(3, 17'd40);
        trip_clear = '0;
        check("clear_beats_event", 64'({odp_trip[3], srp_trip[3], pa_disable[3]}), 64'b001);

        // ODP and SRP on the same edge, then masks raised on a tripped channel.
        do_reset();
        rf_overdrive_avg_per = 21'd1;
        rf_overdrive_thresh = 32'd50;
        rf_slew_limit = 17'd10;
        drive(5, 17'd0);
        drive(5, 17'd100);
        check("odp_srp_same_edge", 64'({odp_trip[5], srp_trip[5]}), 64'b11);
        disable_rf_odp[5] = 1'b1;
        disable_rf_srp[5] = 1'b1;
        tick();
        check("mask_keeps_trip", 64'(pa_disable[5]), 64'd1);

        // Reset mid-window, then the next window counts from zero.
        do_reset();
        rf_overdrive_avg_per = 21'd4;
        rf_slew_limit = 17'd10;
        drive(6, 17'd0); drive(6, 17'd20);
        check("srp6_trip", 64'(pa_disable[6]), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 64'({odp_trip, srp_trip, pa_disable}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        sb.push_back('{tssi: 32'd28, odp: 1'b0, pa: 1'b0});
        for (int i = 0; i < 4; i++) drive(0, 17'd7);
        drain("post_rst_window");
        mon_en = 1'b0;

`ifdef RF_PROT_AUTO_RECOVER_EN
        do_reset();
        rf_slew_limit = 17'd10;
        drive(7, 17'd0); drive(7, 17'd20);
        for (int i = 0; i < AR - 1; i++) tick();
        check("ar_still_tripped", 64'({srp_trip[7], pa_disable[7]}), 64'b11);
        tick();
        check("ar_holdoff", 64'({srp_trip[7], pa_disable[7]}), 64'b01);
        for (int i = 0; i < HO; i++) tick();
        check("ar_rearmed", 64'(pa_disable[7]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_overdrive_protect.md
Name: rf_overdrive_protect

Overview:
- Multi-channel RF power protection engine; consumes the software-set overdrive/slew controls and returns per-channel TSSI.
- Parametrised successor to the fixed 8-channel overdrive fields in the hardware control interface: generalised channel count and sample width.
- Adds a per-channel trip/holdoff state machine that gates PA enable.
- Sits between the DL power-detect datapath and the PA enable/sleep drivers.

Parameters:
NUM_CH, 8, number of RF channels
PWR_W, 17, width of per-channel unsigned power sample and of rf_slew_limit
HOLDOFF_CYC, 1024, clk cycles a channel stays disabled after clear before re-arming (>=1)
AUTO_RECOVER_CYC, 65536, cycles in TRIPPED before automatic clear (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sample_valid  in  1  strobe: all channels' samples valid this cycle
sample_pwr  in  NUM_CH*PWR_W  per-channel power samples, ch0 in LSBs
rf_overdrive_thresh  in  32  ODP threshold, window-sum domain
rf_overdrive_avg_per  in  21  samples per averaging window (0 treated as 1)
rf_slew_limit  in  PWR_W  max allowed rise between consecutive samples
rf_slew_duration_limit  in  16  consecutive violations needed to trip SRP (0 treated as 1)
disable_rf_odp  in  NUM_CH  per-channel ODP detection mask
disable_rf_srp  in  NUM_CH  per-channel SRP detection mask
trip_clear  in  NUM_CH  per-channel single-cycle clear request
rf_overdrive_tssi  out  NUM_CH*32  last completed window sum per channel
tssi_valid  out  1  one-cycle pulse when rf_overdrive_tssi updates
odp_trip  out  NUM_CH  sticky overdrive trip flag
srp_trip  out  NUM_CH  sticky slew trip flag
pa_disable  out  NUM_CH  high = PA must be off

Behaviour:
- Reset: all outputs, accumulators, counters and prev-sample regs 0; all channels in ARMED; prev_valid cleared.
- Window: shared sample counter. avg_per is latched at window start, so mid-window changes take effect next window. Each sample_valid adds sample to a per-channel accumulator of PWR_W+21 bits.
- Window close: on the avg_per-th valid sample's edge:
  - tssi is loaded with the sum including that sample, saturated to 0xFFFF_FFFF.
  - Accumulator restarts at 0; no sample is lost.
  - tssi_valid is high the following cycle.
- ODP: evaluated on the same edge as tssi load. Condition is saturated sum > thresh (strict). If the channel is ARMED and disable_rf_odp[ch]=0: odp_trip[ch] is set and the channel goes to TRIPPED, both visible with tssi_valid.
- SRP, per valid sample:
  - delta = sample - prev when sample > prev, else 0.
  - delta > slew_limit: run_cnt increments (saturating at 0xFFFF); otherwise run_cnt = 0.
  - Trip when run_cnt reaches the duration limit, if ARMED and the mask is 0; sets srp_trip.
  - The first sample after reset or re-arm only loads prev; no slew check on it.
- State machine per channel:
  - ARMED: pa_disable=0. An ODP or SRP event goes to TRIPPED.
  - TRIPPED: pa_disable=1. Further events OR into the sticky flags. trip_clear[ch] goes to HOLDOFF.
  - HOLDOFF: pa_disable=1. odp_trip, srp_trip and run_cnt are cleared on entry. Detections are ignored. After HOLDOFF_CYC cycles, go to ARMED and clear prev_valid.
- pa_disable is driven from the state register; it rises on the edge the trip is registered.
- Simultaneous events:
  - trip_clear in ARMED or HOLDOFF: ignored.
  - trip_clear and a new event on the same cycle in TRIPPED: the clear wins.
  - ODP and SRP on the same edge: both flags set.
- Masks change only detection; a channel already TRIPPED stays TRIPPED when its mask is raised.
- Reset mid-window or mid-holdoff: immediate return to reset values.

Optional Feature:
- Macro: RF_PROT_AUTO_RECOVER_EN.
- Defined: a per-channel counter runs in TRIPPED. After AUTO_RECOVER_CYC cycles without trip_clear, the channel enters HOLDOFF as if cleared. The sticky flags are cleared on that HOLDOFF entry.
- Undefined: TRIPPED exits only via trip_clear; counter logic is absent.

Test Plan:
- avg_per=4, ch0 samples 100 each, thresh=1000 -> after 4th valid sample tssi[0]=400, tssi_valid pulse, no trip; thresh=399 -> odp_trip[0]=1, pa_disable[0]=1 same cycle as tssi_valid.
- Saturation: avg_per=0x1FFFFF, all samples 0x1FFFF -> tssi=0xFFFF_FFFF, no wrap.
- Slew: slew_limit=10, duration=3, ch2 samples 0,20,40,60 -> srp_trip[2] at 4th sample (3 violations); samples 0,20,25,45 -> no trip; disable_rf_srp[2]=1 -> no trip.
- Clear: tripped ch1, trip_clear pulse -> flags 0 next cycle, pa_disable stays 1 for HOLDOFF_CYC cycles then 0; overdrive during holdoff ignored.
- Same-cycle: trip_clear and SRP event on TRIPPED ch3 -> HOLDOFF, flags 0; assert rst mid-window -> all outputs 0, next window starts from count 0.
- With RF_PROT_AUTO_RECOVER_EN, AUTO_RECOVER_CYC=100: tripped channel with no clear -> HOLDOFF after 100 cycles, ARMED after HOLDOFF_CYC more.
